// File: rtl/inst_predecode_queue.sv
// Instruction buffer: assembles NSHIFT-bit beats into INST_BITS words, predecodes
// them and queues them for the decoder. Predecode fields assume a 16-bit encoding.
module inst_predecode_queue #(
    parameter int unsigned NSHIFT    = 2,
    parameter int unsigned INST_BITS = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [NSHIFT-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       inst_valid,
    output logic [INST_BITS-1:0]       inst,
    input  logic                       inst_done,
    output logic                       pd_wide,
    output logic                       pd_branch,
    output logic                       pd_jump,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       partial
);
    localparam int unsigned BEATS = INST_BITS / NSHIFT;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned EW    = INST_BITS + 3;

    logic [BW-1:0]        r_beat;
    logic [INST_BITS-1:0] r_shift;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [EW-1:0]        r_mem [DEPTH];

    logic [INST_BITS-1:0] w_word;
    logic                 w_wide;
    logic                 w_branch;
    logic                 w_jump;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic [EW-1:0]        w_head;

    assign full     = (r_count == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = r_count;
    assign partial  = (r_beat != '0);

    assign w_accept = in_valid && in_ready && !flush;
    assign w_last   = (r_beat == BW'(BEATS - 1));
    assign w_push   = w_accept && w_last;
    assign w_pop    = inst_done && inst_valid && !flush;

    // Current word with this cycle's beat merged in, plus its predecode bits
    always_comb begin
        w_word = r_shift;
        w_word[r_beat * NSHIFT +: NSHIFT] = in_data;

        w_branch = (w_word[15:12] == 4'b0000);
        w_jump   = !w_word[15] && !w_word[14] && (w_word[13] || w_word[12]) &&
                   !w_word[11] && !w_word[10] && !w_word[7] && (w_word[9:8] == 2'b00);

        w_wide = 1'b1;
        if (w_word[15]) begin
            w_wide = 1'b0;
        end else if (w_word[14]) begin
            w_wide = 1'b1;
        end else if (w_word[13]) begin
            // only mov pc,src is wide among the aaa[2] group
            w_wide = (w_word[15:6] == 10'b0010000000);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat  <= '0;
            r_shift <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_beat  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= w_word;
                r_beat  <= w_last ? '0 : r_beat + BW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through r_count
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_tail] <= {w_wide, w_branch, w_jump, w_word};
        end
    end

    assign w_head     = r_mem[r_head];
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? w_head[INST_BITS-1:0] : '0;
    assign pd_jump    = inst_valid && w_head[INST_BITS];
    assign pd_branch  = inst_valid && w_head[INST_BITS+1];
    assign pd_wide    = inst_valid && w_head[INST_BITS+2];

endmodule

// File: tb/tb_inst_predecode_queue.sv
// Directed bench for inst_predecode_queue: vector table for single-word
// assembly plus hand-written sequences for fill, overlap, flush and reset.
module tb_inst_predecode_queue;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_done;
    logic        pd_wide;
    logic        pd_branch;
    logic        pd_jump;
    logic [2:0]  count;
    logic        full;
    logic        partial;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vin;
        logic [1:0]  data;
        logic        done;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [2:0]  e_pd;      // {branch, jump, wide}
        logic [2:0]  e_count;
        logic        e_partial;
    } vec_t;

    vec_t vecs[12];

    inst_predecode_queue #(.NSHIFT(2), .INST_BITS(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .inst_valid(inst_valid),
        .inst      (inst),
        .inst_done (inst_done),
        .pd_wide   (pd_wide),
        .pd_branch (pd_branch),
        .pd_jump   (pd_jump),
        .count     (count),
        .full      (full),
        .partial   (partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic v, input logic [15:0] w,
                            input logic [2:0] pd, input logic [2:0] cnt);
        chk({name, ".valid"}, 32'(inst_valid), 32'(v));
        chk({name, ".inst"},  32'(inst), 32'(w));
        chk({name, ".pd"},    32'({pd_branch, pd_jump, pd_wide}), 32'(pd));
        chk({name, ".count"}, 32'(count), 32'(cnt));
    endtask

    task automatic send_beats(input logic [15:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = w[2*k +: 2];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pop();
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk_head(name, 1'b0, 16'h0, 3'b000, 3'd0);
        chk({name, ".full"},     32'(full), 32'd0);
        chk({name, ".partial"},  32'(partial), 32'd0);
        chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 2'b00;
        flush     = 1'b0;
        inst_done = 1'b0;

        // 16'h8123 as beats 3,0,2,(stall x2),0,1,0,0,2 then pops
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[3]  = '{1'b0, 2'd3, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'h0,    3'b000, 3'd0, 1'b1};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 1'b1, 16'h8123, 3'b000, 3'd1, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h0,    3'b000, 3'd0, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 16'h0,    3'b000, 3'd0, 1'b0};

        #3 reset = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            in_valid  = vecs[i].vin;
            in_data   = vecs[i].data;
            inst_done = vecs[i].done;
            tick();
            chk_head($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst,
                     vecs[i].e_pd, vecs[i].e_count);
            chk($sformatf("vec%0d.partial", i), 32'(partial), 32'(vecs[i].e_partial));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid  = 1'b0;
        inst_done = 1'b0;

        // Predecode of four words, filling the queue
        send_beats(16'h0A05, 8);
        send_beats(16'h2005, 8);
        send_beats(16'h1000, 8);
        send_beats(16'h4000, 8);
        chk_head("fill", 1'b1, 16'h0A05, 3'b101, 3'd4);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 2'd3;
        repeat (3) tick();
        chk("full_offer.partial", 32'(partial), 32'd0);
        chk("full_offer.count", 32'(count), 32'd4);
        inst_done = 1'b1;
        chk("full_pop.in_ready", 32'(in_ready), 32'd0);
        tick();
        inst_done = 1'b0;
        in_valid  = 1'b0;
        chk("after_pop.in_ready", 32'(in_ready), 32'd1);
        chk("after_pop.partial", 32'(partial), 32'd0);
        chk_head("after_pop", 1'b1, 16'h2005, 3'b011, 3'd3);
        send_beats(16'h0123, 8);
        chk("refill.count", 32'(count), 32'd4);
        chk("refill.full", 32'(full), 32'd1);
        pop();
        chk_head("pop1000", 1'b1, 16'h1000, 3'b011, 3'd3);
        pop();
        chk_head("pop4000", 1'b1, 16'h4000, 3'b001, 3'd2);
        pop();
        chk_head("pop0123", 1'b1, 16'h0123, 3'b101, 3'd1);
        pop();
        chk_head("empty", 1'b0, 16'h0, 3'b000, 3'd0);

        // Push and pop in the same cycle with two entries held
        send_beats(16'h1111, 8);
        send_beats(16'h2222, 8);
        chk("overlap_pre.count", 32'(count), 32'd2);
        w = 16'h3333;
        send_beats(w, 7);
        in_valid  = 1'b1;
        in_data   = w[15:14];
        inst_done = 1'b1;
        tick();
        in_valid  = 1'b0;
        inst_done = 1'b0;
        chk("overlap.count", 32'(count), 32'd2);
        chk("overlap.inst", 32'(inst), 32'h2222);
        chk("overlap.partial", 32'(partial), 32'd0);
        pop();
        chk("overlap_next.inst", 32'(inst), 32'h3333);
        chk("overlap_next.count", 32'(count), 32'd1);
        pop();
        chk("overlap_end.count", 32'(count), 32'd0);

        // Flush beats a concurrent beat and pop
        send_beats(16'h5555, 8);
        send_beats(16'h6666, 8);
        w = 16'h7777;
        send_beats(w, 3);
        chk("preflush.partial", 32'(partial), 32'd1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = w[7:6];
        inst_done = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst_done = 1'b0;
        chk_head("flush", 1'b0, 16'h0, 3'b000, 3'd0);
        chk("flush.partial", 32'(partial), 32'd0);
        send_beats(16'h9ABC, 8);
        chk_head("postflush", 1'b1, 16'h9ABC, 3'b000, 3'd1);
        pop();

        // Asynchronous reset between clock edges
        send_beats(16'h1234, 8);
        send_beats(16'h5678, 8);
        send_beats(16'h0F0F, 8);
        send_beats(16'hABCD, 3);
        chk("prereset.count", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        reset = 1'b1;
        tick();
        send_beats(16'h4000, 8);
        chk_head("postreset", 1'b1, 16'h4000, 3'b001, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_predecode_queue.md
# inst_predecode_queue

Parametrised instruction buffer between the serial fetch path and the decoder/scheduler. It assembles instructions arriving NSHIFT bits per cycle, predecodes the fields needed early (width, branch, jump), and stores them in a DEPTH-entry FIFO. It presents the head entry to the decoder using the existing inst_valid/inst_done handshake. A single-cycle flush discards all queued and partially assembled instructions when the PC is redirected.

## Interface
- NSHIFT, 2: bits delivered per input beat; must divide INST_BITS.
- INST_BITS, 16: instruction width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries a valid beat.
- in_data  in  NSHIFT  instruction beat, LSB-first.
- in_ready  out  1  beat is accepted this cycle; equals !full.
- flush  in  1  discard the queue and any partial instruction.
- inst_valid  out  1  head entry valid.
- inst  out  INST_BITS  head instruction; 0 when !inst_valid.
- inst_done  in  1  pop the head; ignored when !inst_valid.
- pd_wide  out  1  head is a 16-bit-register operation; 0 when empty.
- pd_branch  out  1  head is a conditional branch; 0 when empty.
- pd_jump  out  1  head is mov pc,[zp] or mov pc,src; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of stored complete instructions.
- full  out  1  count == DEPTH.
- partial  out  1  assembler holds at least one beat.

## Operation
- **Assembler**
  - Beat counter runs from 0 to INST_BITS/NSHIFT-1.
  - An accepted beat (in_valid && in_ready) is written into bits [k*NSHIFT +: NSHIFT] of the shift register, where k is the current counter value.
  - On the final beat, the complete word (final beat included) is pushed together with its predecode bits, and the counter wraps to 0.
- **Predecode**, computed from the complete word at push time. Field names: b8=i[15], e=i[14], aaa=i[13:11], m=i[10], rr=i[9:8], d=i[7], z=i[6].
  - pd_branch = (i[15:12] == 0).
  - pd_jump = !b8 && !e && (aaa[2]|aaa[1]) && !aaa[0] && !m && !d && rr==0.
  - pd_wide:
    - b8=1 gives 0.
    - Otherwise e=1 gives 1.
    - Otherwise aaa[2]=1 gives 0, except mov pc,src (i[15:6] == 10'b0010000000) gives 1.
    - Otherwise aaa[1]=1 gives 1.
    - Otherwise (branch) gives 1.
- **FIFO**
  - Head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty has no effect.
  - Push when full cannot occur, because in_ready is 0 while full.
- **Flush** (synchronous)
  - Clears count, the pointers and the beat counter.
  - Has priority over a push and a pop in the same cycle: a beat presented with flush is dropped, and a concurrent inst_done is ignored.
- **Reset** (asserted low, asynchronous): same state as after a flush.

## Timing
- Reset values: inst_valid=0, inst=0, pd_*=0, count=0, full=0, partial=0, in_ready=1.
- Latency: the final beat is accepted in cycle N, and with an empty queue inst_valid=1 in cycle N+1. There is no bypass path.
- Pop: inst_done && inst_valid in cycle N moves the next entry to the head in cycle N+1. Back-to-back pops are allowed, one per cycle.
- in_ready is combinational from full only; there is no path from inst_done to in_ready.
- Full boundary: in a cycle where full=1 and a pop occurs, in_ready stays 0. Beats are accepted again from the next cycle.
- Beats can stall mid-instruction for any number of cycles; partial and the accumulated bits hold.
- Flush in cycle N: in cycle N+1 count=0, inst_valid=0 and partial=0, and a beat offered in N+1 is the first beat of a new word.

## Test plan
- Reset, then send 16'h8123 as beats 3,0,2,0,1,0,0,2 -> inst_valid rises in the cycle after the 8th beat, inst=16'h8123, pd_wide=0, pd_branch=0, pd_jump=0, count=1.
- Push 16'h0A05, 16'h2005, 16'h1000, 16'h4000 and pop each -> pd (branch,jump,wide) reads (1,0,1), (0,1,1), (0,1,1), (0,0,1) in order.
- Fill DEPTH=4 with no pops -> full=1, in_ready=0; offered beats are not absorbed; one pop returns in_ready=1 next cycle; the next word completes with count=4.
- Hold count=2 and push a final beat with inst_done in the same cycle -> count stays 2, FIFO order preserved.
- Send 3 beats then assert flush with in_valid=1 and inst_done=1 while 2 entries are queued -> next cycle count=0, partial=0, inst_valid=0; a fresh 8-beat word then emerges intact.
- Deassert reset asynchronously mid-word with 3 entries queued -> all outputs reach reset values immediately, with no clock edge needed.
